sys_mem_slave: RTL and testbench

SYS_MEM_SLAVE -- requirements
Module: sys_mem_slave

---
 rtl/sys_bus_pkg.sv | 24 ++
 rtl/sys_bus_if.sv | 32 +++
 rtl/sys_mem_array.sv | 32 +++
 rtl/sys_mem_slave.sv | 164 ++++++++++++++++
 tb/tb_sys_mem_slave.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_bus_pkg.sv
// Shared types for the sys bus memory slave: default widths, FSM states and
// the saturating 16-bit statistics counter type.
package sys_bus_pkg;

  localparam int SYS_DW    = 64;
  localparam int SYS_AW    = 32;
  localparam int SYS_SW    = SYS_DW / 8;
  localparam int SYS_DEPTH = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef logic [15:0] cnt_t;

  localparam cnt_t CNT_MAX = 16'hFFFF;

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == CNT_MAX) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/sys_bus_if.sv
// Request/acknowledge bus between a sys master and a memory slave.
// Handshake: the master raises sys_wen_i or sys_ren_i with address, data and
// lane enables and holds them stable until it sees sys_ack_o high for one
// cycle; sys_err_o and sys_rdata_o are only meaningful in that ack cycle
// (sys_rdata_o then holds until the next read completes). A request still
// high after the ack cycle is treated as a new access.
interface sys_bus_if #(
  parameter int DW = sys_bus_pkg::SYS_DW,
  parameter int AW = sys_bus_pkg::SYS_AW,
  parameter int SW = sys_bus_pkg::SYS_SW
) ();

  logic [AW-1:0] sys_addr_i;
  logic [DW-1:0] sys_wdata_i;
  logic [SW-1:0] sys_sel_i;
  logic          sys_wen_i;
  logic          sys_ren_i;
  logic [DW-1:0] sys_rdata_o;
  logic          sys_ack_o;
  logic          sys_err_o;

  modport master (
    output sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
    input  sys_rdata_o, sys_ack_o, sys_err_o
  );

  modport slave (
    input  sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
    output sys_rdata_o, sys_ack_o, sys_err_o
  );

endinterface

// File: rtl/sys_mem_array.sv
// Single-port word memory with per-byte-lane write enables and a registered,
// synchronously clearable read port. Contents are never reset.
module sys_mem_array #(
  parameter int DW    = 64,
  parameter int SW    = 8,
  parameter int DEPTH = 1024,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          re,
  input  logic [SW-1:0] we,
  input  logic [IW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < SW; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  // Clear wins so that reset and error completions both present zero data.
  always_ff @(posedge clk) begin
    if (clr)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sys_mem_slave.sv
// Memory slave on the sys bus: IDLE/WAIT/RESP access FSM with programmable
// wait states, address decode against BASE, error detection and statistics.
module sys_mem_slave
  import sys_bus_pkg::*;
#(
  parameter int              DW    = SYS_DW,
  parameter int              AW    = SYS_AW,
  parameter int              SW    = SYS_SW,
  parameter int              DEPTH = SYS_DEPTH,
  parameter int              WAIT  = 0,
  parameter longint unsigned BASE  = 0
) (
  input  logic     axi_clk_i,
  input  logic     axi_rst_i,
  sys_bus_if.slave bus,
  output cnt_t     rd_cnt_o,
  output cnt_t     wr_cnt_o,
  output cnt_t     err_cnt_o,
  output state_t   state_o
);

  localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN      = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [IW-1:0] lat_idx;
  logic [DW-1:0] lat_wdata;
  logic [SW-1:0] lat_sel;
  logic          lat_wr;
  logic          lat_err;
  logic          ack_q;
  logic          err_q;
  cnt_t          rd_cnt;
  cnt_t          wr_cnt;
  cnt_t          err_cnt;

  logic [AW-1:0] addr_in;
  logic [63:0]   in_off;
  logic [IW-1:0] in_idx;
  logic          req;
  logic          in_err;

  logic          go_resp;
  logic [IW-1:0] cur_idx;
  logic [DW-1:0] cur_wdata;
  logic [SW-1:0] cur_sel;
  logic          cur_wr;
  logic          cur_err;

  logic [SW-1:0] arr_we;
  logic          arr_re;
  logic          arr_clr;
  logic [DW-1:0] arr_rdata;

  assign addr_in = bus.sys_addr_i;

  // An address below BASE wraps to a huge offset, so one unsigned compare
  // against the window span covers both ends of the range.
  always_comb begin
    in_off = 64'(addr_in) - BASE;
    in_idx = IW'(in_off >> 3);
    req    = bus.sys_wen_i | bus.sys_ren_i;
    in_err = (in_off >= SPAN) || (bus.sys_wen_i && bus.sys_ren_i);
  end

  // go_resp marks the edge that enters RESP; with no wait states that is the
  // sampling edge itself, so the live bus fields feed the array directly.
  always_comb begin
    go_resp   = 1'b0;
    cur_idx   = lat_idx;
    cur_wdata = lat_wdata;
    cur_sel   = lat_sel;
    cur_wr    = lat_wr;
    cur_err   = lat_err;
    if (state == ST_IDLE) begin
      cur_idx   = in_idx;
      cur_wdata = bus.sys_wdata_i;
      cur_sel   = bus.sys_sel_i;
      cur_wr    = bus.sys_wen_i;
      cur_err   = in_err;
    end
    if (!axi_rst_i) begin
      if (state == ST_IDLE)      go_resp = req && (WAIT == 0);
      else if (state == ST_WAIT) go_resp = (wait_cnt == 4'd0);
    end
    arr_we  = (go_resp && !cur_err && cur_wr) ? cur_sel : '0;
    arr_re  = go_resp && !cur_err && !cur_wr;
    arr_clr = axi_rst_i || (go_resp && cur_err);
  end

  always_ff @(posedge axi_clk_i) begin
    if (axi_rst_i) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_sel   <= '0;
      lat_wr    <= 1'b0;
      lat_err   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      err_cnt   <= '0;
    end else begin
      ack_q <= go_resp;
      err_q <= go_resp && cur_err;
      if (go_resp) begin
        if (cur_err)     err_cnt <= sat_inc(err_cnt);
        else if (cur_wr) wr_cnt  <= sat_inc(wr_cnt);
        else             rd_cnt  <= sat_inc(rd_cnt);
      end
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_idx   <= in_idx;
            lat_wdata <= bus.sys_wdata_i;
            lat_sel   <= bus.sys_sel_i;
            lat_wr    <= bus.sys_wen_i;
            lat_err   <= in_err;
            if (WAIT == 0) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  sys_mem_array #(
    .DW    (DW),
    .SW    (SW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (axi_clk_i),
    .clr   (arr_clr),
    .re    (arr_re),
    .we    (arr_we),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  assign bus.sys_rdata_o = arr_rdata;
  assign bus.sys_ack_o   = ack_q;
  assign bus.sys_err_o   = err_q;
  assign rd_cnt_o        = rd_cnt;
  assign wr_cnt_o        = wr_cnt;
  assign err_cnt_o       = err_cnt;
  assign state_o         = state;

endmodule

// File: tb/tb_sys_mem_slave.sv
// Directed bench for sys_mem_slave: one instance with no wait states at
// BASE 0x2000 and one with three wait states at BASE 0, both DEPTH 1024.
module tb_sys_mem_slave;
  import sys_bus_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sys_bus_if #(.DW(64), .AW(32), .SW(8)) b0 ();
  sys_bus_if #(.DW(64), .AW(32), .SW(8)) b3 ();

  cnt_t   rd0, wr0, er0, rd3, wr3, er3;
  state_t st0, st3;

  sys_mem_slave #(.DW(64), .AW(32), .SW(8), .DEPTH(1024), .WAIT(0), .BASE(64'h2000)) u_dut0 (
    .axi_clk_i (clk), .axi_rst_i (rst), .bus (b0),
    .rd_cnt_o (rd0), .wr_cnt_o (wr0), .err_cnt_o (er0), .state_o (st0)
  );

  sys_mem_slave #(.DW(64), .AW(32), .SW(8), .DEPTH(1024), .WAIT(3), .BASE(64'h0)) u_dut3 (
    .axi_clk_i (clk), .axi_rst_i (rst), .bus (b3),
    .rd_cnt_o (rd3), .wr_cnt_o (wr3), .err_cnt_o (er3), .state_o (st3)
  );

  // master-side drive, routed to the selected instance
  logic        use3 = 1'b0;
  logic [31:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [7:0]  m_sel = '0;
  logic        m_wen = 1'b0;
  logic        m_ren = 1'b0;

  assign b0.sys_addr_i  = m_addr;
  assign b0.sys_wdata_i = m_wdata;
  assign b0.sys_sel_i   = m_sel;
  assign b0.sys_wen_i   = m_wen && !use3;
  assign b0.sys_ren_i   = m_ren && !use3;
  assign b3.sys_addr_i  = m_addr;
  assign b3.sys_wdata_i = m_wdata;
  assign b3.sys_sel_i   = m_sel;
  assign b3.sys_wen_i   = m_wen && use3;
  assign b3.sys_ren_i   = m_ren && use3;

  logic        m_ack, m_err;
  logic [63:0] m_rdata;
  cnt_t        c_rd, c_wr, c_err;
  state_t      m_state;

  assign m_ack   = use3 ? b3.sys_ack_o   : b0.sys_ack_o;
  assign m_err   = use3 ? b3.sys_err_o   : b0.sys_err_o;
  assign m_rdata = use3 ? b3.sys_rdata_o : b0.sys_rdata_o;
  assign c_rd    = use3 ? rd3 : rd0;
  assign c_wr    = use3 ? wr3 : wr0;
  assign c_err   = use3 ? er3 : er0;
  assign m_state = use3 ? st3 : st0;

  // scoreboard
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];

  // driver: request at a negedge, wait (bounded) for ack, drop request in the ack cycle
  task automatic access(input logic wen, input logic ren, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [7:0] sel,
                        output int lat, output logic [63:0] rdata, output logic err);
    lat = 0; rdata = 'x; err = 1'bx;
    @(negedge clk);
    m_addr = addr; m_wdata = wdata; m_sel = sel; m_wen = wen; m_ren = ren;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (m_ack === 1'b1) begin
        lat = n; rdata = m_rdata; err = m_err;
        break;
      end
    end
    m_wen = 1'b0; m_ren = 1'b0;
  endtask

  task automatic test_reset();
    use3 = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", m_ack); end
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", m_err); end
    checks++; if (m_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", m_rdata); end
    checks++; if (c_rd !== 16'd0) begin errors++; $display("FAIL reset_rd_cnt got=%0d exp=0", c_rd); end
    checks++; if (c_wr !== 16'd0) begin errors++; $display("FAIL reset_wr_cnt got=%0d exp=0", c_wr); end
    checks++; if (c_err !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", c_err); end
    checks++; if (m_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", m_state, ST_IDLE); end
  endtask

  task automatic test_write_read();
    int lat; logic [63:0] rd; logic er;
    use3 = 1'b0;
    access(1'b1, 1'b0, 32'h2000, 64'hDEADBEEF12345678, 8'hFF, lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wr_latency got=%0d exp=1", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got=%b exp=0", er); end
    access(1'b0, 1'b1, 32'h2000, 64'h0, 8'h00, lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rd_latency got=%0d exp=1", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", er); end
    checks++; if (rd !== 64'hDEADBEEF12345678) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef12345678", rd); end
    checks++; if (c_wr !== 16'd1) begin errors++; $display("FAIL wr_cnt_1 got=%0d exp=1", c_wr); end
    checks++; if (c_rd !== 16'd1) begin errors++; $display("FAIL rd_cnt_1 got=%0d exp=1", c_rd); end
  endtask

  task automatic test_partial_write();
    int lat; logic [63:0] rd; logic er;
    use3 = 1'b0;
    access(1'b1, 1'b0, 32'h2000, 64'h1111111122222222, 8'h0F, lat, rd, er);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL partial_err got=%b exp=0", er); end
    access(1'b0, 1'b1, 32'h2000, 64'h0, 8'h00, lat, rd, er);
    checks++; if (rd !== 64'hDEADBEEF22222222) begin errors++; $display("FAIL partial_data got=%h exp=deadbeef22222222", rd); end
    // low three address bits select nothing
    access(1'b0, 1'b1, 32'h2007, 64'h0, 8'h00, lat, rd, er);
    checks++; if (rd !== 64'hDEADBEEF22222222) begin errors++; $display("FAIL low_bits_data got=%h exp=deadbeef22222222", rd); end
  endtask

  task automatic test_sel_zero();
    int lat; logic [63:0] rd; logic er;
    use3 = 1'b0;
    access(1'b1, 1'b0, 32'h2000, 64'hFFFFFFFFFFFFFFFF, 8'h00, lat, rd, er);
    checks++; if (lat !== 1 || er !== 1'b0) begin errors++; $display("FAIL sel0_ack lat=%0d err=%b exp lat=1 err=0", lat, er); end
    checks++; if (rd !== 64'hDEADBEEF22222222) begin errors++; $display("FAIL rdata_hold got=%h exp=deadbeef22222222", rd); end
    access(1'b0, 1'b1, 32'h2000, 64'h0, 8'h00, lat, rd, er);
    checks++; if (rd !== 64'hDEADBEEF22222222) begin errors++; $display("FAIL sel0_data got=%h exp=deadbeef22222222", rd); end
    checks++; if (c_wr !== 16'd3) begin errors++; $display("FAIL wr_cnt_3 got=%0d exp=3", c_wr); end
    checks++; if (c_rd !== 16'd4) begin errors++; $display("FAIL rd_cnt_4 got=%0d exp=4", c_rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] rd; logic er; int acks;
    logic [31:0] addrs [2];
    logic [63:0] datas [2];
    use3 = 1'b0;
    addrs[0] = 32'h2008; datas[0] = 64'h0123456789ABCDEF;
    addrs[1] = 32'h3FF8; datas[1] = 64'hFEDCBA9876543210;
    for (int i = 0; i < 2; i++) begin
      access(1'b1, 1'b0, addrs[i], datas[i], 8'hFF, lat, rd, er);
      exp_q.push_back(datas[i]);
    end
    // first word past the window, after a good read left nonzero rdata
    access(1'b0, 1'b1, 32'h4000, 64'h0, 8'h00, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 64'h0) begin errors++; $display("FAIL top_oor err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    for (int i = 0; i < 2; i++) begin
      access(1'b0, 1'b1, addrs[i], 64'h0, 8'h00, lat, rd, er);
      checks++; if (rd !== exp_q[0] || er !== 1'b0) begin errors++; $display("FAIL b2b_read%0d got=%h err=%b exp=%h err=0", i, rd, er, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    access(1'b0, 1'b1, 32'h1FF8, 64'h0, 8'h00, lat, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL below_base err=%b exp=1", er); end
    checks++; if (c_err !== 16'd2) begin errors++; $display("FAIL err_cnt_2 got=%0d exp=2", c_err); end
    // a held read restarts after every ack: ack every other cycle
    acks = 0;
    @(negedge clk);
    m_addr = 32'h2008; m_ren = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (m_ack === 1'b1) acks++;
    end
    m_ren = 1'b0;
    @(negedge clk);
    checks++; if (acks !== 4) begin errors++; $display("FAIL held_read_acks got=%0d exp=4", acks); end
    checks++; if (c_rd !== 16'd10) begin errors++; $display("FAIL rd_cnt_10 got=%0d exp=10", c_rd); end
  endtask

  task automatic test_boundary();
    int lat; logic [63:0] rd; logic er;
    use3 = 1'b1;
    access(1'b1, 1'b0, 32'h1FF8, 64'h0F1E2D3C4B5A6978, 8'hFF, lat, rd, er);
    access(1'b0, 1'b1, 32'h1FF8, 64'h0, 8'h00, lat, rd, er);
    checks++; if (er !== 1'b0 || rd !== 64'h0F1E2D3C4B5A6978) begin errors++; $display("FAIL last_word err=%b rdata=%h exp err=0 rdata=0f1e2d3c4b5a6978", er, rd); end
    access(1'b0, 1'b1, 32'h2000, 64'h0, 8'h00, lat, rd, er);
    checks++; if (lat !== 4) begin errors++; $display("FAIL oor_ack lat=%0d exp=4", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", er); end
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL oor_rdata got=%h exp=0", rd); end
    checks++; if (c_err !== 16'd1) begin errors++; $display("FAIL oor_err_cnt got=%0d exp=1", c_err); end
  endtask

  task automatic test_wait_states();
    int lat; logic [63:0] rd; logic er;
    use3 = 1'b1;
    access(1'b0, 1'b1, 32'h1FF8, 64'h0, 8'h00, lat, rd, er);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wait3_latency got=%0d exp=4", lat); end
    @(negedge clk);
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got=%b exp=0", m_ack); end
  endtask

  task automatic test_both_high();
    int lat; logic [63:0] rd; logic er;
    use3 = 1'b1;
    access(1'b1, 1'b0, 32'h0, 64'hCAFEF00DA5A5A5A5, 8'hFF, lat, rd, er);
    access(1'b1, 1'b1, 32'h0, 64'h0, 8'hFF, lat, rd, er);
    checks++; if (lat !== 4 || er !== 1'b1) begin errors++; $display("FAIL both_err lat=%0d err=%b exp lat=4 err=1", lat, er); end
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL both_rdata got=%h exp=0", rd); end
    access(1'b0, 1'b1, 32'h0, 64'h0, 8'h00, lat, rd, er);
    checks++; if (rd !== 64'hCAFEF00DA5A5A5A5) begin errors++; $display("FAIL both_mem got=%h exp=cafef00da5a5a5a5", rd); end
    checks++; if (c_err !== 16'd2) begin errors++; $display("FAIL both_err_cnt got=%0d exp=2", c_err); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [63:0] rd; logic er; int seen;
    use3 = 1'b1;
    access(1'b1, 1'b0, 32'h100, 64'h5555555555555555, 8'hFF, lat, rd, er);
    @(negedge clk);
    m_addr = 32'h100; m_wdata = 64'hAAAAAAAAAAAAAAAA; m_sel = 8'hFF; m_wen = 1'b1;
    @(negedge clk);
    checks++; if (m_state !== ST_WAIT) begin errors++; $display("FAIL abort_in_wait got=%0d exp=%0d", m_state, ST_WAIT); end
    rst = 1'b1; m_wen = 1'b0;
    seen = 0;
    repeat (2) begin @(negedge clk); if (m_ack === 1'b1) seen++; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (m_ack === 1'b1) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_ack got=%0d acks exp=0", seen); end
    checks++; if (m_state !== ST_IDLE) begin errors++; $display("FAIL abort_state got=%0d exp=%0d", m_state, ST_IDLE); end
    checks++; if (c_rd !== 16'd0 || c_wr !== 16'd0 || c_err !== 16'd0) begin errors++; $display("FAIL abort_counters rd=%0d wr=%0d err=%0d exp all 0", c_rd, c_wr, c_err); end
    checks++; if (m_rdata !== 64'h0) begin errors++; $display("FAIL abort_rdata got=%h exp=0", m_rdata); end
    access(1'b0, 1'b1, 32'h100, 64'h0, 8'h00, lat, rd, er);
    checks++; if (rd !== 64'h5555555555555555) begin errors++; $display("FAIL abort_mem got=%h exp=5555555555555555", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_sel_zero();
    test_back_to_back();
    test_boundary();
    test_wait_states();
    test_both_high();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
